// File: rtl/noc_pkg.sv
// rtl/noc_pkg.sv - NoC command encodings, control-byte layout and message-tx FSM states
// NOC_MSG_TX_CSUM_EN adds the CSUM state to the tx FSM.
package noc_pkg;

  typedef enum logic [2:0] {
    CMD_NOP       = 3'd0,
    CMD_READ      = 3'd1,
    CMD_WRITE     = 3'd2,
    CMD_WRITE_RSP = 3'd4,
    CMD_MESSAGE   = 3'd5
  } noc_cmd_e;

  // Control byte layout: {alen[7:6], dlen[5:3], cmd[2:0]}
  localparam int CTL_CMD_LSB  = 0;
  localparam int CTL_DLEN_LSB = 3;
  localparam int CTL_ALEN_LSB = 6;

  function automatic logic [7:0] noc_ctl_byte(input logic [1:0] alen, input logic [2:0] dlen,
                                              input noc_cmd_e cmd);
    logic [7:0] r;
    r = '0;
    r[CTL_ALEN_LSB +: 2] = alen;
    r[CTL_DLEN_LSB +: 3] = dlen;
    r[CTL_CMD_LSB +: 3]  = cmd;
    return r;
  endfunction

  function automatic logic [7:0] xor_bytes(input logic [63:0] w);
    logic [7:0] x;
    x = '0;
    for (int i = 0; i < 8; i++) x = x ^ w[i*8 +: 8];
    return x;
  endfunction

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_REQ  = 3'd1,
    ST_CTL  = 3'd2,
    ST_DID  = 3'd3,
    ST_SID  = 3'd4,
    ST_IDX  = 3'd5,
    ST_DATA = 3'd6
`ifdef NOC_MSG_TX_CSUM_EN
    , ST_CSUM = 3'd7
`endif
  } tx_state_e;

endpackage

// File: rtl/noc_msg_fifo.sv
// rtl/noc_msg_fifo.sv - result FIFO with extra-bit wrapping pointers
module noc_msg_fifo
#(
  parameter int WIDTH = 72,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     i_push,
  input  logic [WIDTH-1:0]         i_wdata,
  input  logic                     i_pop,
  output logic [WIDTH-1:0]         o_rdata,
  output logic [$clog2(DEPTH):0]   o_count,
  output logic                     o_full,
  output logic                     o_empty
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      r_wptr;
  logic [AW:0]      r_rptr;
  logic             w_do_push;
  logic             w_do_pop;

  assign o_count   = r_wptr - r_rptr;
  assign o_empty   = (r_wptr == r_rptr);
  assign o_full    = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
  assign w_do_pop  = i_pop && !o_empty;
  // A pop in the same cycle frees the slot, so a push to a full FIFO is still accepted.
  assign w_do_push = i_push && (!o_full || w_do_pop);
  assign o_rdata   = r_mem[r_rptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wptr[AW-1:0]] <= i_wdata;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_do_push) r_wptr <= r_wptr + 1'b1;
      if (w_do_pop)  r_rptr <= r_rptr + 1'b1;
    end
  end

endmodule

// File: rtl/noc_msg_tx.sv
// rtl/noc_msg_tx.sv - buffers perm result words and sends each as a NoC MESSAGE packet
// NOC_MSG_TX_CSUM_EN appends an XOR checksum byte after the data bytes.
module noc_msg_tx
  import noc_pkg::*;
#(
  parameter int FIFO_DEPTH  = 8,
  parameter int BLOCK_WORDS = 25
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        pushout,
  input  logic        firstout,
  input  logic [63:0] dout,
  output logic        stopout,
  input  logic [7:0]  dest_id,
  input  logic [7:0]  src_id,
  output logic        tx_req,
  input  logic        tx_gnt,
  output logic        noc_from_dev_ctl,
  output logic [7:0]  noc_from_dev_data,
  output logic        overflow
);
  localparam int         CW       = $clog2(FIFO_DEPTH) + 1;
  localparam logic [7:0] LAST_IDX = 8'(BLOCK_WORDS - 1);
  localparam logic [7:0] MSG_CTL  = noc_ctl_byte(2'b00, 3'b011, CMD_MESSAGE);

  logic [7:0]    w_idx;
  logic [7:0]    r_last_idx;
  logic          w_pop;
  logic          w_full;
  logic          w_empty;
  logic [CW-1:0] w_count;
  logic [71:0]   w_head;
  logic [63:0]   w_head_data;
  logic [7:0]    w_head_idx;
  logic [2:0]    w_next_byte;
  tx_state_e     r_state;
  logic [2:0]    r_byte;
  logic          r_tx_req;
  logic          r_ctl;
  logic [7:0]    r_data;
  logic          r_overflow;

  assign w_idx       = firstout ? 8'd0 : (r_last_idx == LAST_IDX) ? 8'd0 : r_last_idx + 8'd1;
  assign w_head_idx  = w_head[71:64];
  assign w_head_data = w_head[63:0];
  assign w_next_byte = r_byte + 3'd1;

  noc_msg_fifo #(.WIDTH(72), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .i_push  (pushout),
    .i_wdata ({w_idx, dout}),
    .i_pop   (w_pop),
    .o_rdata (w_head),
    .o_count (w_count),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  // The head entry stays in place for the whole packet and is released on its final byte.
`ifdef NOC_MSG_TX_CSUM_EN
  assign w_pop = (r_state == ST_CSUM);
`else
  assign w_pop = (r_state == ST_DATA) && (r_byte == 3'd7);
`endif

  assign stopout           = (w_count >= CW'(FIFO_DEPTH - 2));
  assign overflow          = r_overflow;
  assign tx_req            = r_tx_req;
  assign noc_from_dev_ctl  = r_ctl;
  assign noc_from_dev_data = r_data;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_last_idx <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (pushout) r_last_idx <= w_idx;
      if (pushout && w_full && !w_pop) r_overflow <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= ST_IDLE;
      r_byte   <= '0;
      r_tx_req <= 1'b0;
      r_ctl    <= 1'b1;
      r_data   <= 8'h00;
    end else begin
      case (r_state)
        ST_IDLE: if (!w_empty) begin
          r_state  <= ST_REQ;
          r_tx_req <= 1'b1;
        end
        ST_REQ: if (tx_gnt) begin
          r_state <= ST_CTL;
          r_data  <= MSG_CTL;
        end
        ST_CTL: begin
          r_state <= ST_DID;
          r_ctl   <= 1'b0;
          r_data  <= dest_id;
        end
        ST_DID: begin
          r_state <= ST_SID;
          r_data  <= src_id;
        end
        ST_SID: begin
          r_state <= ST_IDX;
          r_data  <= w_head_idx;
        end
        ST_IDX: begin
          r_state <= ST_DATA;
          r_byte  <= '0;
          r_data  <= w_head_data[7:0];
        end
        ST_DATA: if (r_byte != 3'd7) begin
          r_byte <= w_next_byte;
          r_data <= w_head_data[{w_next_byte, 3'b000} +: 8];
        end else begin
`ifdef NOC_MSG_TX_CSUM_EN
          r_state <= ST_CSUM;
          r_data  <= xor_bytes(w_head_data);
`else
          r_state  <= ST_IDLE;
          r_tx_req <= 1'b0;
          r_ctl    <= 1'b1;
          r_data   <= 8'h00;
`endif
        end
`ifdef NOC_MSG_TX_CSUM_EN
        ST_CSUM: begin
          r_state  <= ST_IDLE;
          r_tx_req <= 1'b0;
          r_ctl    <= 1'b1;
          r_data   <= 8'h00;
        end
`endif
        default: begin
          r_state  <= ST_IDLE;
          r_tx_req <= 1'b0;
          r_ctl    <= 1'b1;
          r_data   <= 8'h00;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_noc_msg_tx.sv
// tb/tb_noc_msg_tx.sv - self-checking bench for noc_msg_tx against a packet-level reference model
module tb_noc_msg_tx;
  localparam int DEPTH = 8;
  localparam int BW    = 25;
`ifdef NOC_MSG_TX_CSUM_EN
  localparam int PLEN = 13;
`else
  localparam int PLEN = 12;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        pushout;
  logic        firstout;
  logic [63:0] dout;
  logic        stopout;
  logic [7:0]  dest_id;
  logic [7:0]  src_id;
  logic        tx_req;
  logic        tx_gnt;
  logic        ctl;
  logic [7:0]  data;
  logic        overflow;

  always #5 clk = ~clk;

  noc_msg_tx #(.FIFO_DEPTH(DEPTH), .BLOCK_WORDS(BW)) dut (
    .clk               (clk),
    .reset             (reset),
    .pushout           (pushout),
    .firstout          (firstout),
    .dout              (dout),
    .stopout           (stopout),
    .dest_id           (dest_id),
    .src_id            (src_id),
    .tx_req            (tx_req),
    .tx_gnt            (tx_gnt),
    .noc_from_dev_ctl  (ctl),
    .noc_from_dev_data (data),
    .overflow          (overflow)
  );

  int n_cmp = 0;
  int n_bad = 0;

  logic [71:0]  exp_q[$];
  int           m_last_idx = 0;
  bit           no_pop_mode = 0;
  logic [103:0] rx_b_q[$];
  logic [12:0]  rx_c_q[$];
  logic [12:0]  rx_r_q[$];
  logic [7:0]   rx_idx_log[$];
  logic         so_d1 = 1'b0;
  logic         so_d2 = 1'b0;

  // perm-side view of stopout: a push at edge k obeys the value sampled at edge k-2
  always @(posedge clk) begin
    so_d1 <= stopout;
    so_d2 <= so_d1;
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic model_push(input logic [63:0] d, input logic f);
    int idx;
    idx = f ? 0 : (m_last_idx + 1) % BW;
    m_last_idx = idx;
    if (!(no_pop_mode && exp_q.size() >= DEPTH)) exp_q.push_back({8'(idx), d});
  endtask

  task automatic push_one(input logic [63:0] d, input logic f, input bit honor);
    int w;
    w = 0;
    while (honor && so_d2 && w < 500) begin
      @(negedge clk);
      w++;
    end
    if (w >= 500) chk("push_wait", so_d2, 0);
    pushout  = 1'b1;
    firstout = f;
    dout     = d;
    @(posedge clk);
    model_push(d, f);
    @(negedge clk);
    pushout  = 1'b0;
    firstout = 1'b0;
  endtask

  function automatic logic [103:0] exp_bytes(input logic [71:0] e);
    logic [103:0] r;
    logic [7:0]   x;
    r = '0;
    x = '0;
    r[7:0]   = 8'h1D;
    r[15:8]  = dest_id;
    r[23:16] = src_id;
    r[31:24] = e[71:64];
    for (int k = 0; k < 8; k++) begin
      r[32 + 8*k +: 8] = e[8*k +: 8];
      x = x ^ e[8*k +: 8];
    end
    if (PLEN == 13) r[103:96] = x;
    return r;
  endfunction

  task automatic check_packets(input int n);
    int w;
    logic [71:0]  e;
    logic [103:0] b;
    logic [12:0]  c;
    logic [12:0]  r;
    w = 0;
    while (rx_b_q.size() < n && w < 3000) begin
      @(negedge clk);
      w++;
    end
    chk("rx_count", rx_b_q.size(), n);
    for (int i = 0; i < n && rx_b_q.size() > 0 && exp_q.size() > 0; i++) begin
      e = exp_q.pop_front();
      b = rx_b_q.pop_front();
      c = rx_c_q.pop_front();
      r = rx_r_q.pop_front();
      chk("pkt_bytes", b, exp_bytes(e));
      chk("pkt_ctl", c, 13'h0001);
      chk("pkt_req", r, (PLEN == 13) ? 13'h1FFF : 13'h0FFF);
      rx_idx_log.push_back(b[31:24]);
    end
  endtask

  initial begin
    int cnt;
    logic [103:0] mb;
    logic [12:0]  mc;
    logic [12:0]  mr;
    cnt = -1;
    mb = '0;
    mc = '0;
    mr = '0;
    forever begin
      @(negedge clk);
      if (reset) cnt = -1;
      else if (cnt < 0) begin
        if (ctl && data == 8'h1D) begin
          mb = '0; mc = '0; mr = '0;
          mb[7:0] = 8'h1D; mc[0] = 1'b1; mr[0] = tx_req;
          cnt = 1;
        end
      end else begin
        mb[cnt*8 +: 8] = data;
        mc[cnt] = ctl;
        mr[cnt] = tx_req;
        cnt++;
        if (cnt == PLEN) begin
          rx_b_q.push_back(mb);
          rx_c_q.push_back(mc);
          rx_r_q.push_back(mr);
          cnt = -1;
        end
      end
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] d;
    reset = 1'b1; pushout = 1'b0; firstout = 1'b0; dout = '0;
    dest_id = 8'hA5; src_id = 8'h3C; tx_gnt = 1'b0;
    step(3);
    chk("rst_ctl", ctl, 1'b1);
    chk("rst_data", data, 8'h00);
    chk("rst_req", tx_req, 1'b0);
    chk("rst_stop", stopout, 1'b0);
    chk("rst_ovf", overflow, 1'b0);
    reset = 1'b0;
    step(2);

    // single word: latency and byte order
    tx_gnt = 1'b1;
    push_one(64'h0807060504030201, 1'b1, 1'b1);
    chk("lat_req_t0", tx_req, 1'b0);
    step(1);
    chk("lat_req_t1", tx_req, 1'b1);
    chk("lat_nop_ctl", ctl, 1'b1);
    chk("lat_nop_data", data, 8'h00);
    step(1);
    chk("lat_ctl_t2", {ctl, data}, {1'b1, 8'h1D});
    step(11);
    chk("lat_last_t13", {tx_req, ctl, data}, {1'b1, 1'b0, 8'h08});
    step(1);
`ifdef NOC_MSG_TX_CSUM_EN
    chk("csum_byte", {tx_req, ctl, data}, {1'b1, 1'b0, 8'h08});
`else
    chk("end_idle", {tx_req, ctl, data}, {1'b0, 1'b1, 8'h00});
`endif
    check_packets(1);

    // full 25-word block, then a new block start
    rx_idx_log.delete();
    for (int i = 0; i < 28; i++)
      push_one({$urandom, $urandom}, (i == 0) || (i == 25), 1'b1);
    check_packets(28);
    chk("idx_24", rx_idx_log[24], 8'd24);
    chk("idx_wrap", rx_idx_log[25], 8'd0);
    chk("idx_next", rx_idx_log[26], 8'd1);
    chk("ovf_after_block", overflow, 1'b0);

    // random words, random gaps, grant toggling between pushes
    for (int i = 0; i < 30; i++) begin
      for (int g = 0; g < int'($urandom_range(0, 3)); g++) begin
        tx_gnt = 1'($urandom);
        step(1);
      end
      tx_gnt = 1'b1;
      push_one({$urandom, $urandom}, (i == 0) || ($urandom_range(0, 5) == 0), 1'b1);
    end
    tx_gnt = 1'b1;
    check_packets(30);
    chk("ovf_after_rand", overflow, 1'b0);

    // grant withheld, perm pushes every allowed cycle
    step(5);
    tx_gnt = 1'b0;
    no_pop_mode = 1'b1;
    for (int i = 0; i < 14; i++) begin
      if (!so_d2) begin
        d = {$urandom, $urandom};
        pushout = 1'b1; firstout = (i == 0); dout = d;
        @(posedge clk);
        model_push(d, (i == 0));
        @(negedge clk);
      end else begin
        pushout = 1'b0; firstout = 1'b0;
        step(1);
      end
      pushout = 1'b0; firstout = 1'b0;
      chk("stop_level", stopout, exp_q.size() >= DEPTH - 2);
      chk("stop_no_ovf", overflow, 1'b0);
    end
    chk("stop_req_held", tx_req, 1'b1);

    // forced pushes into a full FIFO are dropped
    for (int i = 0; i < 3; i++) push_one({$urandom, $urandom}, 1'b0, 1'b0);
    chk("ovf_set", overflow, 1'b1);
    no_pop_mode = 1'b0;
    tx_gnt = 1'b1;
    check_packets(DEPTH);
    step(3);
    chk("ovf_sticky", overflow, 1'b1);
    chk("stop_drained", stopout, 1'b0);

    // reset during DATA byte 4 abandons the packet
    d = {$urandom, $urandom};
    push_one(d, 1'b1, 1'b1);
    step(10);
    chk("pre_rst_byte4", {ctl, data}, {1'b0, d[39:32]});
    #1 reset = 1'b1;
    #1;
    chk("async_rst", {tx_req, ctl, data, overflow, stopout}, {1'b0, 1'b1, 8'h00, 1'b0, 1'b0});
    step(1);
    chk("rst_next_cycle", {tx_req, ctl, data}, {1'b0, 1'b1, 8'h00});
    reset = 1'b0;
    exp_q.delete();
    m_last_idx = 0;
    step(20);
    chk("post_rst_idle", {tx_req, ctl, data}, {1'b0, 1'b1, 8'h00});
    chk("post_rst_no_pkt", rx_b_q.size(), 0);

    push_one({$urandom, $urandom}, 1'b0, 1'b1);
    check_packets(1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/noc_msg_tx.md
NOC_MSG_TX -- requirements
Module: noc_msg_tx

Interface
REQ-001 Parameter FIFO_DEPTH, default 8, number of 72-bit entries (64 data + 8 index) in the result FIFO; power of two, >=4.
REQ-002 Parameter BLOCK_WORDS, default 25, number of 64-bit words in one permutation result block.
REQ-003 clk  input  1  single clock; all state on rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 pushout  input  1  perm output word valid this cycle.
REQ-006 firstout  input  1  qualifies pushout; word is word 0 of a result block.
REQ-007 dout  input  64  perm output word.
REQ-008 stopout  output  1  backpressure to perm; perm stops pushing 2 cycles after sampling it high.
REQ-009 dest_id / src_id  input  8 each  static NoC ids placed in every message header.
REQ-010 tx_req  output  1  request for the shared noc_from_dev byte channel.
REQ-011 tx_gnt  input  1  channel granted to this block.
REQ-012 noc_from_dev_ctl  output  1  byte is a control byte.
REQ-013 noc_from_dev_data  output  8  NoC byte.
REQ-014 overflow  output  1  sticky: word pushed while FIFO full.

Function
REQ-015 Each FIFO entry SHALL hold dout plus an 8-bit word index; index = 0 when firstout, else previous index + 1, wrapping BLOCK_WORDS-1 -> 0.
REQ-016 FIFO SHALL use wrapping read/write pointers with one extra bit; simultaneous push and pop on a full or empty FIFO SHALL keep count consistent (push to full with pop same cycle accepted).
REQ-017 stopout SHALL be high whenever registered count >= FIFO_DEPTH-2.
REQ-018 Push while full with no pop SHALL drop the word, not move pointers, and set overflow until reset.
REQ-019 FSM states: IDLE, REQ, CTL, DID, SID, IDX, DATA, (CSUM when compiled), back to IDLE.
REQ-020 IDLE -> REQ when FIFO non-empty; tx_req SHALL be high from REQ through the last packet byte, low otherwise.
REQ-021 REQ -> CTL on the cycle after tx_gnt is sampled high; tx_gnt low holds REQ indefinitely.
REQ-022 CTL drives ctl=1, data=8'h1D ({alen=2'b00, dlen=3'b011, cmd=3'b101 MESSAGE}).
REQ-023 DID drives dest_id, SID src_id, IDX the entry index, DATA 8 bytes dout[7:0] first to dout[63:56] last, all with ctl=0.
REQ-024 FIFO pop SHALL occur on the last DATA byte cycle; a non-empty FIFO then SHALL go IDLE -> REQ without extra idle cycles beyond one IDLE cycle.
REQ-025 In IDLE and REQ the block SHALL drive NOP: ctl=1, data=8'h00.
REQ-026 Latency: word pushed at cycle t into empty FIFO, tx_gnt high -> tx_req at t+1, CTL byte at t+2, last data byte at t+13.
REQ-027 tx_gnt dropping mid-packet SHALL be ignored; a packet always completes.

Reset
REQ-028 Reset SHALL immediately force: state IDLE, pointers/count/index 0, overflow 0, tx_req 0, stopout 0, ctl 1, data 8'h00.
REQ-029 Reset mid-packet SHALL abandon the packet; no partial resume after release.

Configuration
REQ-030 With NOC_MSG_TX_CSUM_EN defined, CSUM state follows DATA and drives ctl=0, data = XOR of the 8 data bytes; pop moves to the CSUM cycle; tx_req covers it.
REQ-031 Without NOC_MSG_TX_CSUM_EN, no CSUM state exists and packets are 12 bytes.

Structure
REQ-032 Shared package noc_pkg SHALL hold the cmd encodings (NOP=0, READ=1, WRITE=2, WRITE_RSP=4, MESSAGE=5), the control-byte field layout, and the FSM state enum.
REQ-033 FIFO SHALL be a sub-module noc_msg_fifo (parameterised width/depth, count, full/empty).

Verification
REQ-034 One word 64'h0807060504030201 with firstout, tx_gnt=1 -> bytes 1D,dest,src,00,01..08; ctl=1 only on 1D.
REQ-035 25-word block then another firstout -> indices 0..24 then 0.
REQ-036 tx_gnt held low, perm pushes every cycle -> stopout high at count 6, no overflow with 2-cycle perm stop latency.
REQ-037 Force push when full -> overflow=1, later packets carry earlier words unchanged.
REQ-038 Reset asserted during DATA byte 4 -> next cycle ctl=1, data=00, tx_req=0, FIFO empty.
REQ-039 CSUM_EN build, data 64'h0807060504030201 -> trailing byte 8'h08.
